// File: rtl/window_spot_detect.sv
`default_nettype none
// ============================================================================
// Module      : window_spot_detect
// Description : Sums each incoming 3x3 pixel window in a three-stage pipeline.
//               Across one frame it keeps the earliest window with the largest
//               sum that reaches a runtime threshold. At end of frame it reports
//               that window's coordinates and sum as the laser-spot estimate.
// Revision    : 1.0 - initial release
// ============================================================================
module window_spot_detect #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [71:0]   window_i,
    input  logic          window_valid_i,
    input  logic          sof_i,
    input  logic [11:0]   threshold_i,
    output logic [CW-1:0] spot_x_o,
    output logic [CW-1:0] spot_y_o,
    output logic [11:0]   spot_sum_o,
    output logic          spot_found_o,
    output logic          result_valid_o,
    output logic          busy_o
);

    localparam logic [CW-1:0] c_x_max = CW'(IMG_W - 1);
    localparam logic [CW-1:0] c_y_max = CW'(IMG_H - 1);
    localparam logic [CW-1:0] c_one   = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Frame position counters and the "last sample already tagged" flag
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          done_q, done_d;

    // Stage 1: row sums plus sideband
    logic [2:0][9:0] s1_row_q, s1_row_d;
    logic            s1_valid_q, s1_valid_d;
    logic [CW-1:0]   s1_x_q, s1_x_d;
    logic [CW-1:0]   s1_y_q, s1_y_d;
    logic            s1_last_q, s1_last_d;

    // Stage 2: window total plus sideband
    logic [11:0]     s2_sum_q, s2_sum_d;
    logic            s2_valid_q, s2_valid_d;
    logic [CW-1:0]   s2_x_q, s2_x_d;
    logic [CW-1:0]   s2_y_q, s2_y_d;
    logic            s2_last_q, s2_last_d;

    // Stage 3: running best of the frame
    logic [11:0]     best_sum_q, best_sum_d;
    logic [CW-1:0]   spot_x_q, spot_x_d;
    logic [CW-1:0]   spot_y_q, spot_y_d;
    logic            found_q, found_d;

    logic [2:0][9:0] w_row_sum;
    logic            w_accept;
    logic [CW-1:0]   w_tag_x;
    logic [CW-1:0]   w_tag_y;
    logic            w_tag_last;
    logic            w_update;

    // A sof sample always starts a fresh frame at (0,0); otherwise samples are
    // taken only while accumulating and before the last one has been tagged.
    assign w_accept   = window_valid_i &&
                        (sof_i || ((state_q == ST_ACCUM) && !done_q));
    assign w_tag_x    = sof_i ? '0 : x_q;
    assign w_tag_y    = sof_i ? '0 : y_q;
    assign w_tag_last = (w_tag_x == c_x_max) && (w_tag_y == c_y_max);

    // Strict greater-than keeps the earliest of equal sums.
    assign w_update   = (state_q == ST_ACCUM) && s2_valid_q &&
                        (s2_sum_q >= threshold_i) &&
                        (!found_q || (s2_sum_q > best_sum_q));

    generate
        for (genvar r = 0; r < 3; r++) begin : g_row
            assign w_row_sum[r] = {2'b00, window_i[24*r      +: 8]} +
                                  {2'b00, window_i[24*r + 8  +: 8]} +
                                  {2'b00, window_i[24*r + 16 +: 8]};
        end
    endgenerate

    // Next-state of the frame FSM; a sof in ACCUM wins over a finishing frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sof_i) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (sof_i)                        state_d = ST_ACCUM;
                else if (s2_valid_q && s2_last_q) state_d = ST_REPORT;
            end
            ST_REPORT: begin
                state_d = sof_i ? ST_ACCUM : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Coordinate tagging: clear on sof, then advance past each accepted sample
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        done_d = done_q;
        if (sof_i) begin
            x_d    = '0;
            y_d    = '0;
            done_d = 1'b0;
        end
        if (w_accept) begin
            if (w_tag_x == c_x_max) begin
                x_d = '0;
                y_d = w_tag_y + c_one;
            end else begin
                x_d = w_tag_x + c_one;
                y_d = w_tag_y;
            end
            if (w_tag_last) done_d = 1'b1;
        end
    end

    // Pipeline next-state; a sof drops everything in flight
    always_comb begin
        s1_row_d   = w_row_sum;
        s1_valid_d = w_accept;
        s1_x_d     = w_tag_x;
        s1_y_d     = w_tag_y;
        s1_last_d  = w_tag_last;
        s2_sum_d   = {2'b00, s1_row_q[0]} + {2'b00, s1_row_q[1]} +
                     {2'b00, s1_row_q[2]};
        s2_valid_d = s1_valid_q && !sof_i;
        s2_x_d     = s1_x_q;
        s2_y_d     = s1_y_q;
        s2_last_d  = s1_last_q;
    end

    // Best-window tracking; holds after the report until the next sof
    always_comb begin
        best_sum_d = best_sum_q;
        spot_x_d   = spot_x_q;
        spot_y_d   = spot_y_q;
        found_d    = found_q;
        if (sof_i) begin
            best_sum_d = '0;
            spot_x_d   = '0;
            spot_y_d   = '0;
            found_d    = 1'b0;
        end else if (w_update) begin
            best_sum_d = s2_sum_q;
            spot_x_d   = s2_x_q;
            spot_y_d   = s2_y_q;
            found_d    = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            done_q     <= 1'b0;
            s1_row_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_last_q  <= 1'b0;
            s2_sum_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_x_q     <= '0;
            s2_y_q     <= '0;
            s2_last_q  <= 1'b0;
            best_sum_q <= '0;
            spot_x_q   <= '0;
            spot_y_q   <= '0;
            found_q    <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            done_q     <= done_d;
            s1_row_q   <= s1_row_d;
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_last_q  <= s1_last_d;
            s2_sum_q   <= s2_sum_d;
            s2_valid_q <= s2_valid_d;
            s2_x_q     <= s2_x_d;
            s2_y_q     <= s2_y_d;
            s2_last_q  <= s2_last_d;
            best_sum_q <= best_sum_d;
            spot_x_q   <= spot_x_d;
            spot_y_q   <= spot_y_d;
            found_q    <= found_d;
        end
    end

    assign spot_x_o       = spot_x_q;
    assign spot_y_o       = spot_y_q;
    assign spot_sum_o     = best_sum_q;
    assign spot_found_o   = found_q;
    assign result_valid_o = (state_q == ST_REPORT);
    assign busy_o         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_window_spot_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_spot_detect
// Description : Directed self-checking bench for window_spot_detect on a 4x3
//               frame, with a frame-level reference model and literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_spot_detect;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [71:0]   window_i = '0;
    logic          window_valid_i = 1'b0;
    logic          sof_i = 1'b0;
    logic [11:0]   threshold_i = '0;
    logic [CW-1:0] spot_x_o;
    logic [CW-1:0] spot_y_o;
    logic [11:0]   spot_sum_o;
    logic          spot_found_o;
    logic          result_valid_o;
    logic          busy_o;

    window_spot_detect #(.IMG_W(W), .IMG_H(H), .CW(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .window_i       (window_i),
        .window_valid_i (window_valid_i),
        .sof_i          (sof_i),
        .threshold_i    (threshold_i),
        .spot_x_o       (spot_x_o),
        .spot_y_o       (spot_y_o),
        .spot_sum_o     (spot_sum_o),
        .spot_found_o   (spot_found_o),
        .result_valid_o (result_valid_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pulses = 0;
    int last_drive_cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int bsum(input logic [71:0] w);
        int s = 0;
        for (int k = 0; k < 9; k++) s += int'(w[8*k +: 8]);
        return s;
    endfunction

    function automatic logic [71:0] fill(input logic [7:0] b);
        return {9{b}};
    endfunction

    // ---------------- frame-level reference model ----------------
    // Collects the sums of the accepted samples of a frame; once the frame is
    // complete it scans them for the earliest maximum at or above threshold.
    int   m_sum [N];
    int   m_cnt = 0;
    int   m_cd  = 0;
    int   r_x = 0, r_y = 0, r_sum = 0, r_found = 0;
    logic exp_rv = 1'b0, exp_busy = 1'b0, exp_found = 1'b0;
    int   exp_x = 0, exp_y = 0, exp_sum = 0;

    always @(posedge clk) begin
        logic was_rep;
        logic acc;
        int   best;
        int   bs;
        cyc++;
        if (rst) begin
            m_cnt = 0; m_cd = 0;
            exp_rv = 0; exp_busy = 0; exp_found = 0;
            exp_x = 0; exp_y = 0; exp_sum = 0;
        end else begin
            was_rep = exp_rv;
            exp_rv  = 1'b0;
            if (m_cd > 0) begin
                m_cd--;
                if (m_cd == 0) begin
                    exp_rv = 1'b1;
                    exp_x = r_x; exp_y = r_y; exp_sum = r_sum; exp_found = (r_found != 0);
                end
            end
            acc = window_valid_i && (sof_i || (exp_busy && !was_rep && m_cnt < N));
            if (sof_i) begin
                m_cd = 0; exp_rv = 1'b0; m_cnt = 0; exp_busy = 1'b1;
                exp_x = 0; exp_y = 0; exp_sum = 0; exp_found = 1'b0;
            end else if (was_rep) begin
                exp_busy = 1'b0;
            end
            if (acc) begin
                m_sum[m_cnt] = bsum(window_i);
                m_cnt++;
                if (m_cnt == N) begin
                    best = -1; bs = 0;
                    for (int i = 0; i < N; i++)
                        if (m_sum[i] >= int'(threshold_i) && (best < 0 || m_sum[i] > bs)) begin
                            best = i; bs = m_sum[i];
                        end
                    if (best >= 0) begin
                        r_found = 1; r_x = best % W; r_y = best / W; r_sum = bs;
                    end else begin
                        r_found = 0; r_x = 0; r_y = 0; r_sum = 0;
                    end
                    m_cd = 2;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("result_valid", int'(result_valid_o), int'(exp_rv));
            chk("busy", int'(busy_o), int'(exp_busy));
            if (!exp_busy || exp_rv) begin
                chk("spot_x", int'(spot_x_o), exp_x);
                chk("spot_y", int'(spot_y_o), exp_y);
                chk("spot_sum", int'(spot_sum_o), exp_sum);
                chk("spot_found", int'(spot_found_o), int'(exp_found));
            end
            if (result_valid_o) pulses++;
        end
    end

    // ---------------- stimulus ----------------
    logic [71:0] pat [N];

    task automatic step(input logic v, input logic s, input logic [71:0] w);
        window_i = w; window_valid_i = v; sof_i = s;
        if (v) last_drive_cyc = cyc;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < N; i++) begin
            step(1'b1, i == 0, pat[i]);
            if (gaps && (i % 3 == 1) && i != N - 1) idle(1 + (i % 2));
        end
    endtask

    task automatic wait_pulse(input string nm, output int at);
        at = -1;
        for (int i = 0; i < 12; i++) begin
            if (result_valid_o) begin at = cyc; return; end
            idle(1);
        end
        chk({nm, "_pulse_timeout"}, 0, 1);
    endtask

    task automatic lit(input string nm, input int x, input int y, input int s, input int f);
        chk({nm, "_x"}, int'(spot_x_o), x);
        chk({nm, "_y"}, int'(spot_y_o), y);
        chk({nm, "_sum"}, int'(spot_sum_o), s);
        chk({nm, "_found"}, int'(spot_found_o), f);
    endtask

    initial begin
        int at;
        int p0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        lit("reset", 0, 0, 0, 0);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_rv", int'(result_valid_o), 0);

        // Single peak
        threshold_i = 12'd100;
        for (int i = 0; i < N; i++) pat[i] = '0;
        pat[6] = fill(8'h20);
        send_frame(1'b0);
        wait_pulse("peak", at);
        chk("peak_latency", at - last_drive_cyc, 3);
        lit("peak", 2, 1, 288, 1);
        idle(2);

        // Reset held two cycles mid-frame
        p0 = pulses;
        for (int i = 0; i < 3; i++) step(1'b1, i == 0, fill(8'h40));
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        lit("midrst", 0, 0, 0, 0);
        chk("midrst_busy", int'(busy_o), 0);
        idle(8);
        chk("midrst_no_pulse", pulses, p0);

        // Tie and threshold
        threshold_i = 12'd300;
        for (int i = 0; i < N; i++) pat[i] = '0;
        pat[2] = fill(8'd100);
        pat[9] = fill(8'd100);
        pat[5] = fill(8'd33);
        send_frame(1'b0);
        wait_pulse("tie", at);
        lit("tie", 2, 0, 900, 1);
        idle(2);

        // Nothing qualifies
        threshold_i = 12'd2296;
        for (int i = 0; i < N; i++) pat[i] = fill(8'hFF);
        send_frame(1'b0);
        wait_pulse("noq", at);
        chk("noq_rv", int'(result_valid_o), 1);
        lit("noq", 0, 0, 0, 0);
        idle(2);

        // Abort then gapped frame
        threshold_i = 12'd10;
        p0 = pulses;
        for (int i = 0; i < 5; i++)
            step(1'b1, i == 0, (i == 3) ? {56'd0, 8'd245, 8'd255} : 72'd50);
        for (int i = 0; i < N; i++) pat[i] = 72'd50;
        send_frame(1'b1);
        wait_pulse("abort", at);
        lit("abort", 0, 0, 50, 1);
        idle(6);
        chk("abort_one_pulse", pulses - p0, 1);

        // Back-to-back: sof with a sample during REPORT
        for (int i = 0; i < N; i++) pat[i] = 72'd50;
        pat[7] = fill(8'd10);
        send_frame(1'b0);
        idle(2);
        chk("b2b_report_rv", int'(result_valid_o), 1);
        lit("b2b_first", 3, 1, 90, 1);
        step(1'b1, 1'b1, fill(8'd20));
        chk("b2b_busy_held", int'(busy_o), 1);
        for (int i = 1; i < N; i++) step(1'b1, 1'b0, 72'd50);
        wait_pulse("b2b", at);
        lit("b2b_second", 0, 0, 180, 1);
        idle(4);
        chk("b2b_idle_busy", int'(busy_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/window_spot_detect.md
# window_spot_detect

Downstream consumer of the 9-pixel window shift register: takes each 72-bit 3x3 window and sums its pixels in a pipeline. Across one frame it tracks the window with the largest sum that meets a runtime threshold. At end of frame it reports that window's coordinates and sum, which is the laser-spot estimate used by the position/tracking logic.

## Interface
- IMG_W, 640: windows per line (x count).
- IMG_H, 480: lines per frame (y count).
- CW, 10: coordinate width; must satisfy 2^CW >= max(IMG_W, IMG_H).
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset: one clock; reset is synchronous and active-high.
- window  in  72  3x3 pixel window; byte k = window[8k+7:8k], k=0..8, unsigned.
- window_valid  in  1  window is a new sample this cycle.
- sof  in  1  start-of-frame strobe; clears frame state.
- threshold  in  12  minimum sum for a window to qualify; sampled each cycle at stage 3.
- spot_x  out  CW  x of best window.
- spot_y  out  CW  y of best window.
- spot_sum  out  12  sum of best window.
- spot_found  out  1  at least one window qualified this frame.
- result_valid  out  1  one-cycle pulse; spot_* valid and frame complete.
- busy  out  1  high in ACCUM and REPORT.

## Operation
- FSM states: IDLE, ACCUM, REPORT. Reset enters IDLE.
- IDLE:
  - window_valid is ignored.
  - sof moves to ACCUM, clears the x/y counters, best_sum, spot_found and pipeline valids.
- ACCUM:
  - Each window_valid sample is tagged with the current (x,y).
  - x increments each sample. At x=IMG_W-1, x wraps to 0 and y increments.
  - The sample at (IMG_W-1, IMG_H-1) is tagged last. Samples after last, before the FSM leaves ACCUM, are ignored.
- sof with window_valid in the same cycle, in IDLE or ACCUM: clear first, then accept that sample as (0,0).
- sof in ACCUM otherwise: restart the frame. In-flight pipeline samples are discarded and no result_valid is produced for the aborted frame.
- Pipeline, valid/coord/last travel with the data:
  - S1: three row sums (bytes 0-2, 3-5, 6-8), 10 bits each, registered.
  - S2: total sum, 12 bits, registered. Max 2295; no overflow.
  - S3 update rule: if sum >= threshold and (spot_found==0 or sum > best_sum), load best_sum, spot_x, spot_y and set spot_found.
  - Ties keep the earliest window (strict >).
- When the last sample completes S3, the FSM goes to REPORT.
- REPORT lasts one cycle with result_valid=1, then returns to IDLE.
  - If sof is asserted during REPORT, the pulse is still issued, then the FSM goes to ACCUM with state cleared.
  - A window_valid in that cycle is accepted as (0,0).
- spot_x, spot_y, spot_sum and spot_found hold their values after REPORT until the next sof clears them.
- If nothing qualified: spot_found=0 and spot_x, spot_y, spot_sum=0 at REPORT.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, pipeline valids 0.
- rst overrides everything, including mid-frame and in REPORT; no result pulse.
- Latency: last sample's window_valid at cycle t gives result_valid high at cycle t+3.
  - S1 registers at t+1, S2 at t+2, S3 update and state change at t+3 edge; REPORT is visible in cycle t+3.
- Throughput: one window per cycle, no backpressure; window_valid may be asserted every cycle or with gaps.
- busy: rises the cycle after sof is sampled; falls the cycle after REPORT, unless sof was sampled in REPORT.

## Test plan
Bench uses IMG_W=4, IMG_H=3 (12 samples).
- Reset: hold rst 2 cycles mid-frame -> all outputs 0, busy=0, no result_valid.
- Single peak: threshold=100, all windows 0x00 except sample 6 = all bytes 0x20 (sum 288) -> result_valid exactly 3 cycles after sample 11, spot_x=2, spot_y=1, spot_sum=288, spot_found=1.
- Tie and threshold:
  - threshold=300.
  - Samples 2 and 9 have sum 900 (all bytes 100); sample 5 has sum 297.
  - Required: spot=(2,0), spot_sum=900.
- No qualify: threshold=2296, full-white frame (all 0xFF, sum 2295) -> result_valid=1, spot_found=0, spot_sum=0.
- Abort and gaps:
  - Frame 1: sof, 5 samples including a peak sum 500, then sof with window_valid.
  - Frame 2: 12 samples with random gaps, all sum 50, threshold=10.
  - Required: exactly one result_valid, spot=(0,0), spot_sum=50.
- Back-to-back: sof during REPORT with window_valid -> pulse issued, next frame counts that sample as (0,0), busy stays high.
